// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, address layout and sequencer states shared by the SDRAM line master
package sdram_pkg;
  typedef enum logic [2:0] {
    CMD_ACTIVE = 3'b011,
    CMD_WRITE  = 3'b100,
    CMD_READ   = 3'b101,
    CMD_NOP    = 3'b111
  } cmd_e;
  localparam int BANK_W   = 2;
  localparam int ROW_W    = 11;
  localparam int COL_W    = 8;
  localparam int COL_OFF  = 0;
  localparam int ROW_OFF  = COL_OFF + COL_W;
  localparam int BANK_OFF = ROW_OFF + ROW_W;
  localparam int ADDR_W   = BANK_OFF + BANK_W;
  localparam int TAG_W    = BANK_W + ROW_W;
  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_ACTIVATE,
    S_ACT_WAIT,
    S_WRITE,
    S_RECOVER,
    S_READ_CMD,
    S_READ_WAIT,
    S_READ_DATA,
    S_DONE
  } state_e;
endpackage

// File: rtl/sdram_ack_monitor.sv
// sdram_ack_monitor: times the oldest unacknowledged command and latches a sticky err on timeout
module sdram_ack_monitor #(
  parameter int ACK_WINDOW = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_en,
  input  logic cmd_ack,
  output logic err
);
  localparam logic [7:0] LIM = 8'(ACK_WINDOW);
  logic       run;
  logic [7:0] cnt;
  // one timer for the oldest outstanding command: ack clears it, a new command while waiting does not restart it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      run <= cmd_en | (run & ~cmd_ack);
      cnt <= (run & ~cmd_ack) ? (cnt == LIM ? cnt : cnt + 8'd1) : {7'd0, cmd_en};
      err <= err | (run & ~cmd_ack & cnt == LIM - 8'd1);
    end
endmodule

// File: rtl/sdram_line_master.sv
// sdram_line_master: cache-line ACTIVE/WRITE/READ sequencer for the Gowin SDRAM controller user port; define OPEN_ROW_EN to keep rows open and skip ACTIVATE on a row hit
module sdram_line_master
  import sdram_pkg::*;
#(
  parameter int BURST_LEN    = 8,
  parameter int ACT_TO_RW    = 2,
  parameter int READ_LATENCY = 6,
  parameter int WR_RECOVERY  = 4,
  parameter int ACK_WINDOW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [20:0]            req_addr,
  input  logic [BURST_LEN*32-1:0] wr_line,
  output logic [BURST_LEN*32-1:0] rd_line,
  output logic                   done,
  output logic                   err,
  input  logic                   sdrc_init_done,
  input  logic                   sdrc_cmd_ack,
  input  logic [31:0]            sdrc_rd_data,
  output logic                   sdrc_cmd_en,
  output logic [2:0]             sdrc_cmd,
  output logic [20:0]            sdrc_addr,
  output logic [7:0]             sdrc_data_len,
  output logic [31:0]            sdrc_wr_data,
  output logic [3:0]             sdrc_dqm,
  output logic                   sdrc_precharge_ctrl,
  output logic                   sdrc_power_down,
  output logic                   sdrc_selfrefresh
);
  localparam logic [7:0] ACT_END = 8'(ACT_TO_RW - 2);
  localparam logic [7:0] BL_END  = 8'(BURST_LEN - 1);
  localparam logic [7:0] WR_END  = 8'(WR_RECOVERY - 1);
  localparam logic [7:0] RL_END  = 8'(READ_LATENCY - 2);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};
  state_e                  state, state_n;
  logic [7:0]              cnt;
  logic                    wr_q, hit;
  logic [ADDR_W-1:0]       addr_q;
  logic [BURST_LEN*32-1:0] line_q, line_n;
`ifdef OPEN_ROW_EN
  logic             open_v;
  logic [TAG_W-1:0] open_tag;
  // remember which bank/row the last ACTIVATE left open
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      open_v   <= 1'b0;
      open_tag <= '0;
    end else if (state == S_ACTIVATE) begin
      open_v   <= 1'b1;
      open_tag <= addr_q[ADDR_W-1:ROW_OFF];
    end
  assign hit = open_v && open_tag == req_addr[ADDR_W-1:ROW_OFF];
  assign sdrc_precharge_ctrl = 1'b0;
`else
  assign hit = 1'b0;
  assign sdrc_precharge_ctrl = 1'b1;
`endif
  assign req_ready        = state == S_IDLE;
  assign done             = state == S_DONE;
  assign sdrc_addr        = addr_q;
  assign sdrc_data_len    = 8'(BURST_LEN);
  assign sdrc_dqm         = 4'b0000;
  assign sdrc_power_down  = 1'b0;
  assign sdrc_selfrefresh = 1'b0;
  // state register plus a per-state cycle counter that restarts on every state change and saturates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_INIT_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? 8'd0 : cnt == 8'hff ? cnt : cnt + 8'd1;
    end
  // fixed-timing command sequence; each command strobes for exactly one cycle
  always_comb begin
    state_n      = state;
    sdrc_cmd_en  = 1'b0;
    sdrc_cmd     = CMD_NOP;
    sdrc_wr_data = '0;
    case (state)
      S_INIT_WAIT: state_n = sdrc_init_done ? S_IDLE : S_INIT_WAIT;
      S_IDLE:      if (req_valid) state_n = !hit ? S_ACTIVATE : req_write ? S_WRITE : S_READ_CMD;
      S_ACTIVATE: begin
        sdrc_cmd_en = 1'b1;
        sdrc_cmd    = CMD_ACTIVE;
        state_n     = S_ACT_WAIT;
      end
      S_ACT_WAIT:  if (cnt == ACT_END) state_n = wr_q ? S_WRITE : S_READ_CMD;
      S_WRITE: begin
        sdrc_cmd_en  = cnt == 8'd0;
        sdrc_cmd     = cnt == 8'd0 ? CMD_WRITE : CMD_NOP;
        sdrc_wr_data = line_q[cnt[2:0]*32 +: 32];
        if (cnt == BL_END) state_n = WR_RECOVERY == 0 ? S_DONE : S_RECOVER;
      end
      S_RECOVER:   if (cnt == WR_END) state_n = S_DONE;
      S_READ_CMD: begin
        sdrc_cmd_en = 1'b1;
        sdrc_cmd    = CMD_READ;
        state_n     = READ_LATENCY > 1 ? S_READ_WAIT : S_READ_DATA;
      end
      S_READ_WAIT: if (cnt == RL_END) state_n = S_READ_DATA;
      S_READ_DATA: if (cnt == BL_END) state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_INIT_WAIT;
    endcase
  end
  // line buffer with the current read word merged in, so rd_line is complete while done is high
  always_comb begin
    line_n = line_q;
    line_n[cnt[2:0]*32 +: 32] = sdrc_rd_data;
  end
  // latch the accepted request; the write line doubles as the fill buffer, published on the last word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
      rd_line <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        wr_q   <= req_write;
        addr_q <= req_addr & LINE_MASK;
        line_q <= wr_line;
      end
      if (state == S_READ_DATA) line_q <= line_n;
      if (state == S_READ_DATA && cnt == BL_END) rd_line <= line_n;
    end
  sdram_ack_monitor #(.ACK_WINDOW(ACK_WINDOW)) u_ack (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_en  (sdrc_cmd_en),
    .cmd_ack (sdrc_cmd_ack),
    .err     (err)
  );
endmodule

// File: tb/tb_sdram_line_master.sv
// tb_sdram_line_master: directed and random line transfers against a memory-backed controller model
module tb_sdram_line_master;
  localparam int BL = 8, ATR = 2, RL = 6, WRR = 4, AW = 16, W = BL * 32, CW = W + 64;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic sdrc_init_done = 1'b0, sdrc_cmd_ack = 1'b0;
  logic [20:0] req_addr = '0;
  logic [W-1:0] wr_line = '0, rd_line;
  logic req_ready, done, err;
  logic [31:0] sdrc_rd_data = '0;
  logic sdrc_cmd_en;
  logic [2:0] sdrc_cmd;
  logic [20:0] sdrc_addr;
  logic [7:0] sdrc_data_len;
  logic [31:0] sdrc_wr_data;
  logic [3:0] sdrc_dqm;
  logic sdrc_precharge_ctrl, sdrc_power_down, sdrc_selfrefresh;
  int cyc = 0, passed = 0, total = 0, done_n = 0, err_c = -1, rd_c = -1, wr_c = -1, last_act = 0;
  bit ack_en = 1'b1, prev_en = 1'b0;
  logic [20:0] rd_base = '0, wbase = '0;
  typedef struct {int c; logic [2:0] cmd; logic [20:0] a;} ev_t;
  ev_t ev;
  ev_t log_q[$];
  logic [31:0] cmem[int];
  logic [31:0] ref_mem[int];
  logic [31:0] wd[int];

  sdram_line_master #(.BURST_LEN(BL), .ACT_TO_RW(ATR), .READ_LATENCY(RL), .WR_RECOVERY(WRR), .ACK_WINDOW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .wr_line(wr_line), .rd_line(rd_line), .done(done), .err(err),
    .sdrc_init_done(sdrc_init_done), .sdrc_cmd_ack(sdrc_cmd_ack), .sdrc_rd_data(sdrc_rd_data),
    .sdrc_cmd_en(sdrc_cmd_en), .sdrc_cmd(sdrc_cmd), .sdrc_addr(sdrc_addr), .sdrc_data_len(sdrc_data_len),
    .sdrc_wr_data(sdrc_wr_data), .sdrc_dqm(sdrc_dqm), .sdrc_precharge_ctrl(sdrc_precharge_ctrl),
    .sdrc_power_down(sdrc_power_down), .sdrc_selfrefresh(sdrc_selfrefresh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(int a);
    return cmem.exists(a) ? cmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] l;
    for (int k = 0; k < BL; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // mid-cycle observer and controller model: command log, write capture into memory, acks, read data after RL cycles
  always @(negedge clk) begin
    if (sdrc_cmd_en) begin
      ev.c = cyc; ev.cmd = sdrc_cmd; ev.a = sdrc_addr;
      log_q.push_back(ev);
    end
    wd[cyc] = sdrc_wr_data;
    if (done) done_n++;
    if (err && err_c < 0) err_c = cyc;
    sdrc_cmd_ack = ack_en && prev_en;
    prev_en = sdrc_cmd_en;
    if (sdrc_cmd_en && sdrc_cmd == 3'b100) begin wr_c = cyc; wbase = sdrc_addr; end
    if (sdrc_cmd_en && sdrc_cmd == 3'b101) begin rd_c = cyc; rd_base = sdrc_addr; end
    if (wr_c >= 0 && cyc - wr_c < BL) cmem[int'(wbase) + cyc - wr_c] = sdrc_wr_data;
    sdrc_rd_data = (rd_c >= 0 && cyc - rd_c >= RL && cyc - rd_c < RL + BL) ? mem_rd(int'(rd_base) + cyc - rd_c - RL) : $urandom;
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_txn(input bit w, input logic [20:0] a, input logic [W-1:0] line);
    int t0, n, act_c, rw_c, done_c;
    logic [20:0] al;
    logic [W-1:0] exp_l, obs_l, rd_at_done;
    al = {a[20:3], 3'b000};
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("txn_ready", CW'(req_ready), CW'(1));
    log_q.delete();
    req_valid = 1'b1; req_write = w; req_addr = a; wr_line = line; t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 21'($urandom); wr_line = rand_line();
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("txn_done_seen", CW'(done), CW'(1));
    done_c = cyc;
    rd_at_done = rd_line;
    @(negedge clk);
    chk("txn_done_pulse_ready", CW'({done, req_ready}), CW'(2'b01));
    act_c = t0 + 1;
    rw_c = act_c + ATR;
    last_act = act_c;
    chk("txn_cmd_count", CW'(log_q.size()), CW'(2));
    if (log_q.size() == 2) begin
      chk("txn_active", CW'({log_q[0].c, log_q[0].cmd, log_q[0].a}), CW'({act_c, 3'b011, al}));
      chk("txn_rw", CW'({log_q[1].c, log_q[1].cmd, log_q[1].a}), CW'({rw_c, w ? 3'b100 : 3'b101, al}));
    end
    if (w) begin
      for (int k = 0; k < BL; k++) begin
        obs_l[k*32 +: 32] = wd[rw_c + k];
        ref_mem[int'(al) + k] = line[k*32 +: 32];
      end
      chk("wr_data", CW'(obs_l), CW'(line));
      chk("wr_done_time", CW'(done_c), CW'(rw_c + BL + WRR));
    end else begin
      for (int k = 0; k < BL; k++) exp_l[k*32 +: 32] = ref_rd(int'(al) + k);
      chk("rd_line", CW'(rd_at_done), CW'(exp_l));
      chk("rd_done_time", CW'(done_c), CW'(rw_c + RL + BL));
    end
  endtask

  initial begin
    logic [W-1:0] ev_line;
    logic [20:0] a;
    int t0, dn;
    ev_line = {32'h0bba5a50, 32'h0abafef0, 32'h0bcdef00, 32'h02345670,
               32'habba5a5a, 32'hbabafefe, 32'habcdef01, 32'h12345678};
    repeat (3) @(negedge clk);
    chk("rst_handshake", CW'({req_ready, done, err, sdrc_cmd_en}), CW'(0));
    chk("rst_cmd_pre", CW'({sdrc_cmd, sdrc_precharge_ctrl}), CW'(4'b1111));
    chk("rst_rd_line", CW'(rd_line), CW'(0));
    chk("rst_static", CW'({sdrc_data_len, sdrc_dqm, sdrc_power_down, sdrc_selfrefresh, sdrc_wr_data, sdrc_addr}),
        CW'({8'(BL), 4'd0, 1'b0, 1'b0, 32'd0, 21'd0}));
    rst_n = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("init_hold", CW'({sdrc_cmd_en, req_ready}), CW'(0));
    end
    req_valid = 1'b0; sdrc_init_done = 1'b1;
    chk("init_ready_pre", CW'(req_ready), CW'(0));
    @(negedge clk);
    chk("init_ready_post", CW'(req_ready), CW'(1));
    do_txn(1'b1, 21'h0, ev_line);
    do_txn(1'b0, 21'h0, rand_line());
    do_txn(1'b1, 21'h000103, rand_line());
    do_txn(1'b0, 21'h000105, rand_line());
    for (int i = 0; i < 24; i++) begin
      a = {2'($urandom_range(0, 3)), 11'($urandom_range(0, 2)), 8'($urandom)};
      do_txn(1'($urandom), a, rand_line());
    end
    chk("err_clear", CW'(err), CW'(0));
    ack_en = 1'b0; err_c = -1;
    do_txn(1'b1, 21'h1a0340, rand_line());
    repeat (5) @(negedge clk);
    chk("err_rise_time", CW'(err_c), CW'(last_act + AW));
    do_txn(1'b0, 21'h1a0340, rand_line());
    chk("err_sticky", CW'(err), CW'(1));
    ack_en = 1'b1;
    while (!req_ready) @(negedge clk);
    log_q.delete();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h0; t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (ATR + RL + 3) @(negedge clk);
    dn = done_n;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_handshake", CW'({req_ready, done, err, sdrc_cmd_en}), CW'(0));
    chk("rst_mid_cmd_pre", CW'({sdrc_cmd, sdrc_precharge_ctrl, sdrc_wr_data, sdrc_addr}), CW'({3'b111, 1'b1, 32'd0, 21'd0}));
    chk("rst_mid_rd_line", CW'(rd_line), CW'(0));
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", CW'(done_n), CW'(dn));
    chk("rst_mid_cmds", CW'(log_q.size()), CW'(2));
    chk("rst_mid_read_time", CW'(rd_c), CW'(t0 + 1 + ATR));
    rst_n = 1'b1;
    do_txn(1'b0, 21'h0, rand_line());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sdram_line_master.md
Name: sdram_line_master

Overview:
- Initiator that drives the Gowin SDRAM controller user interface (SDRAM_Controller_HS_Top I_sdrc_*/O_sdrc_* ports) on behalf of the cache.
- Converts one cache-line request (fill or evict) into the ACTIVE → WRITE/READ burst sequence with fixed inter-command timing.
- Returns the read line or a completion pulse.
- Sits between the cache and the SDRAM controller; replaces hand-sequenced commands.

Parameters:
- BURST_LEN, 8, 32-bit words per cache line; legal values 1..8.
- ACT_TO_RW, 2, cycles from ACTIVE pulse to READ/WRITE pulse (minimum 2).
- READ_LATENCY, 6, cycles from READ pulse to first valid O_sdrc_data word.
- WR_RECOVERY, 4, idle cycles after the last write word before the next request is accepted.
- ACK_WINDOW, 16, cycles to wait for O_sdrc_cmd_ack after any command.

Ports:
- clk  in  1  controller user clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  line request present
- req_ready  out  1  block idle and initialised
- req_write  in  1  1 = evict (write), 0 = fill (read)
- req_addr  in  21  line word address {bank[1:0], row[10:0], col[7:0]}; col low 3 bits ignored (line-aligned)
- wr_line  in  BURST_LEN*32  evict data, word 0 in bits [31:0]
- rd_line  out  BURST_LEN*32  fill data, word 0 in bits [31:0]
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: command not acknowledged within ACK_WINDOW
- sdrc_init_done  in  1  from controller
- sdrc_cmd_ack  in  1  from controller
- sdrc_rd_data  in  32  from controller
- sdrc_cmd_en  out  1  command strobe
- sdrc_cmd  out  3  111 NOP, 011 ACTIVE, 100 WRITE, 101 READ
- sdrc_addr  out  21  command address
- sdrc_data_len  out  8  burst length
- sdrc_wr_data  out  32  write data
- sdrc_dqm  out  4  byte mask
- sdrc_precharge_ctrl, sdrc_power_down, sdrc_selfrefresh  out  1 each

Behaviour:
- Reset values (asynchronous on rst_n low):
  - All outputs 0, except sdrc_cmd = 111 and sdrc_precharge_ctrl = 1.
  - rd_line = 0, err = 0, state = INIT_WAIT.
  - A reset mid-burst aborts immediately; no further command is issued.
- Static outputs: sdrc_power_down = 0, sdrc_selfrefresh = 0, sdrc_dqm = 0000, sdrc_data_len = BURST_LEN.
- Command strobe: sdrc_cmd_en is high exactly one cycle per command. sdrc_cmd returns to NOP the following cycle.
- INIT_WAIT → IDLE once sdrc_init_done = 1. A request arriving before init is held off (req_ready = 0).
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch req_write, req_addr (col[2:0] forced to 0) and wr_line.
  - Go to ACTIVATE.
- ACTIVATE: cmd_en = 1, cmd = 011, addr = latched. Then ACT_WAIT for ACT_TO_RW-1 NOP cycles.
- WRITE:
  - Cycle 0: cmd_en = 1, cmd = 100, sdrc_wr_data = word 0.
  - Words 1..BURST_LEN-1 on the following consecutive cycles.
  - Then RECOVER for WR_RECOVERY cycles, then DONE.
- READ:
  - READ_CMD: cmd_en = 1, cmd = 101.
  - READ_WAIT: READ_LATENCY-1 cycles.
  - READ_DATA: capture BURST_LEN consecutive words into rd_line[k*32 +: 32], then DONE.
- DONE:
  - done = 1 for one cycle; rd_line stays valid until the next fill completes.
  - Return to IDLE; req_ready rises the cycle after done.
- Ack monitor:
  - A counter starts at each cmd_en pulse and clears on sdrc_cmd_ack.
  - If it reaches ACK_WINDOW, err sets and stays set until reset.
  - The sequence continues regardless (timing is fixed, ack is diagnostic only).
- Simultaneity and range:
  - A req_valid that stays asserted during done is not accepted until IDLE.
  - Counters are 8 bits wide.
  - Counters saturate and never wrap within legal parameter ranges.

Optional Feature:
- Macro OPEN_ROW_EN.
- Defined:
  - sdrc_precharge_ctrl = 0 and the block tracks the open bank/row (valid bit + 13-bit tag).
  - A request hitting the open row skips ACTIVATE/ACT_WAIT and goes straight to WRITE/READ_CMD.
  - A miss issues ACTIVATE for the new row (the controller handles precharge).
  - Reset clears the valid bit.
- Undefined: sdrc_precharge_ctrl = 1 (auto-precharge) and every request activates.

Decomposition:
- Package sdram_pkg:
  - Command enum (NOP/ACTIVE/WRITE/READ encodings).
  - Address field widths and offsets (bank 2, row 11, col 8).
  - State enum.
- One sub-module, sdram_ack_monitor: ACK_WINDOW counter plus sticky err.

Test Plan:
- Hold sdrc_init_done = 0 for 100 cycles with req_valid = 1 → no cmd_en, req_ready = 0; release → req_ready = 1 one cycle later.
- Evict addr 0, wr_line words 12345678, abcdef01, babafefe, abba5a5a, 02345670, 0bcdef00, 0abafef0, 0bba5a50 → ACTIVE at t, WRITE at t+2 with 12345678, remaining words t+3..t+9, done at t+14.
- Fill addr 0 after that evict, using the mt48lc2m32b2 model → rd_line equals the same eight words; done at READ+6+8.
- Fill req_addr 0x00_0105 → sdrc_addr on ACTIVE/READ = 0x00_0100.
- Tie sdrc_cmd_ack = 0 → err rises 16 cycles after ACTIVE, remains high, line still completes; rst_n low mid-READ_DATA → outputs at reset values, no done.
- OPEN_ROW_EN defined, two fills in the same row → second has no ACTIVE; different row → ACTIVE reissued.
